// File: rtl/temporizador_mmss.sv
// temporizador_mmss: programmable MM:SS countdown timer.
// It holds a BCD preset and counts down one second for each 1 Hz tick
// under start/stop control. Reaching 00:00 raises a one-cycle fin_pulse
// and holds done for DONE_TICKS ticks before returning to IDLE.
// Exactly one request acts per cycle: the highest-priority asserted input
// (stop > load > start > tick). If that input is not legal in the current
// state, the cycle does nothing, so lower-priority inputs are dropped.
module temporizador_mmss #(
  parameter int DONE_TICKS = 3
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic [3:0] ld_min_d,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_d,
  input  logic [3:0] ld_sec_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] sec_d,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       fin_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DONE_LAST = 4'(DONE_TICKS);

  state_t     state_q, state_d;
  logic [3:0] min_d_q, min_d_d;
  logic [3:0] min_u_q, min_u_d;
  logic [3:0] sec_d_q, sec_d_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [3:0] done_cnt_q, done_cnt_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       fin_pulse_q, fin_pulse_d;

  logic       act_stop, act_load, act_start, act_tick;
  logic [3:0] cl_min_d, cl_min_u, cl_sec_d, cl_sec_u;
  logic       count_zero, count_one;

  // Clamp the preset digits so the count always stays within 00:00..99:59.
  always_comb begin
    cl_min_d = (ld_min_d > 4'd9) ? 4'd9 : ld_min_d;
    cl_min_u = (ld_min_u > 4'd9) ? 4'd9 : ld_min_u;
    cl_sec_d = (ld_sec_d > 4'd5) ? 4'd5 : ld_sec_d;
    cl_sec_u = (ld_sec_u > 4'd9) ? 4'd9 : ld_sec_u;
  end

  // Pick the single highest-priority request for this cycle.
  always_comb begin
    act_stop  = stop;
    act_load  = load  & ~stop;
    act_start = start & ~stop & ~load;
    act_tick  = tick  & ~stop & ~load & ~start;
    count_zero = (min_d_q == 4'd0) && (min_u_q == 4'd0) &&
                 (sec_d_q == 4'd0) && (sec_u_q == 4'd0);
    count_one  = (min_d_q == 4'd0) && (min_u_q == 4'd0) &&
                 (sec_d_q == 4'd0) && (sec_u_q == 4'd1);
  end

  // Next-state, next-count and registered-output decode.
  always_comb begin
    state_d     = state_q;
    min_d_d     = min_d_q;
    min_u_d     = min_u_q;
    sec_d_d     = sec_d_q;
    sec_u_d     = sec_u_q;
    done_cnt_d  = done_cnt_q;
    fin_pulse_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (act_load) begin
          min_d_d = cl_min_d;
          min_u_d = cl_min_u;
          sec_d_d = cl_sec_d;
          sec_u_d = cl_sec_u;
        end else if (act_start && !count_zero) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (act_stop) begin
          state_d = PAUSE;
        end else if (act_tick && !count_zero) begin
          if (sec_u_q != 4'd0) begin
            sec_u_d = sec_u_q - 4'd1;
          end else begin
            sec_u_d = 4'd9;
            if (sec_d_q != 4'd0) begin
              sec_d_d = sec_d_q - 4'd1;
            end else begin
              sec_d_d = 4'd5;
              if (min_u_q != 4'd0) begin
                min_u_d = min_u_q - 4'd1;
              end else begin
                min_u_d = 4'd9;
                min_d_d = min_d_q - 4'd1;
              end
            end
          end
          if (count_one) begin
            state_d     = DONE;
            done_cnt_d  = 4'd0;
            fin_pulse_d = 1'b1;
          end
        end
      end

      PAUSE: begin
        if (act_load) begin
          state_d = IDLE;
          min_d_d = cl_min_d;
          min_u_d = cl_min_u;
          sec_d_d = cl_sec_d;
          sec_u_d = cl_sec_u;
        end else if (act_start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (act_load) begin
          state_d = IDLE;
          min_d_d = cl_min_d;
          min_u_d = cl_min_u;
          sec_d_d = cl_sec_d;
          sec_u_d = cl_sec_u;
        end else if (act_tick) begin
          if (done_cnt_q + 4'd1 >= DONE_LAST) begin
            state_d = IDLE;
          end
          done_cnt_d = done_cnt_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  // State, count and output registers; reset discards any count in progress.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      min_d_q     <= 4'd0;
      min_u_q     <= 4'd0;
      sec_d_q     <= 4'd0;
      sec_u_q     <= 4'd0;
      done_cnt_q  <= 4'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      fin_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_d_q     <= min_d_d;
      min_u_q     <= min_u_d;
      sec_d_q     <= sec_d_d;
      sec_u_q     <= sec_u_d;
      done_cnt_q  <= done_cnt_d;
      running_q   <= running_d;
      done_q      <= done_d;
      fin_pulse_q <= fin_pulse_d;
    end
  end

  assign min_d     = min_d_q;
  assign min_u     = min_u_q;
  assign sec_d     = sec_d_q;
  assign sec_u     = sec_u_q;
  assign running   = running_q;
  assign done      = done_q;
  assign fin_pulse = fin_pulse_q;

endmodule

// File: tb/tb_temporizador_mmss.sv
// tb_temporizador_mmss: directed, self-checking bench for temporizador_mmss.
// Each step drives inputs for one clock and compares against hand-derived values.
module tb_temporizador_mmss;

  logic       mclk;
  logic       reset;
  logic       tick, start, stop, load;
  logic [3:0] ld_min_d, ld_min_u, ld_sec_d, ld_sec_u;
  logic [3:0] min_d, min_u, sec_d, sec_u;
  logic       running, done, fin_pulse;

  int vectors;
  int miscompares;

  temporizador_mmss #(.DONE_TICKS(3)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .ld_min_d  (ld_min_d),
    .ld_min_u  (ld_min_u),
    .ld_sec_d  (ld_sec_d),
    .ld_sec_u  (ld_sec_u),
    .min_d     (min_d),
    .min_u     (min_u),
    .sec_d     (sec_d),
    .sec_u     (sec_u),
    .running   (running),
    .done      (done),
    .fin_pulse (fin_pulse)
  );

  // 100 MHz-style free-running clock for simulation.
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Drive one cycle of request pulses; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic p_tick, input logic p_start,
                               input logic p_stop, input logic p_load);
    tick  = p_tick;
    start = p_start;
    stop  = p_stop;
    load  = p_load;
    @(posedge mclk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  // Set the preset digits presented on the ld_* inputs.
  task automatic setPreset(input logic [15:0] p);
    ld_min_d = p[15:12];
    ld_min_u = p[11:8];
    ld_sec_d = p[7:4];
    ld_sec_u = p[3:0];
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] count();
    return {min_d, min_u, sec_d, sec_u};
  endfunction

  // Linear sequence of directed steps.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    tick = 0; start = 0; stop = 0; load = 0;
    setPreset(16'h0000);
    repeat (2) @(posedge mclk);
    #1;
    checkOutput("reset_count", count(), 16'h0000);
    checkOutput("reset_running", {15'd0, running}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_fin", {15'd0, fin_pulse}, 16'd0);
    reset = 1'b0;

    $display("[TB] asynchronous reset mid-RUN at 01:23");
    setPreset(16'h0123);
    applyStimulus(0, 0, 0, 1);
    checkOutput("load_0123", count(), 16'h0123);
    applyStimulus(0, 1, 0, 0);
    checkOutput("start_running", {15'd0, running}, 16'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_count", count(), 16'h0000);
    checkOutput("async_rst_running", {15'd0, running}, 16'd0);
    checkOutput("async_rst_done", {15'd0, done}, 16'd0);
    #1 reset = 1'b0;
    applyStimulus(0, 1, 0, 0);
    checkOutput("start_after_rst", {15'd0, running}, 16'd0);

    $display("[TB] 01:00 full countdown");
    setPreset(16'h0100);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("run_0100", {15'd0, running}, 16'd1);
    checkOutput("tick_start_count", count(), 16'h0100);
    applyStimulus(1, 0, 0, 0);
    checkOutput("first_tick", count(), 16'h0059);
    for (int i = 0; i < 58; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("tick59_count", count(), 16'h0001);
    checkOutput("tick59_fin", {15'd0, fin_pulse}, 16'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("tick60_count", count(), 16'h0000);
    checkOutput("tick60_fin", {15'd0, fin_pulse}, 16'd1);
    checkOutput("tick60_done", {15'd0, done}, 16'd1);
    checkOutput("tick60_running", {15'd0, running}, 16'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fin_one_cycle", {15'd0, fin_pulse}, 16'd0);
    checkOutput("done_hold", {15'd0, done}, 16'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("done_after_2", {15'd0, done}, 16'd1);
    checkOutput("done_count_hold", count(), 16'h0000);
    applyStimulus(1, 0, 0, 0);
    checkOutput("done_after_3", {15'd0, done}, 16'd0);
    checkOutput("idle_running", {15'd0, running}, 16'd0);

    $display("[TB] pause and resume");
    setPreset(16'h0010);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("three_ticks", count(), 16'h0007);
    applyStimulus(1, 0, 1, 0);
    checkOutput("stop_tick_count", count(), 16'h0007);
    checkOutput("stop_running", {15'd0, running}, 16'd0);
    repeat (5) applyStimulus(1, 0, 0, 0);
    checkOutput("pause_hold", count(), 16'h0007);
    applyStimulus(0, 1, 0, 0);
    checkOutput("resume_running", {15'd0, running}, 16'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume_tick", count(), 16'h0006);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("stop_start_pause", {15'd0, running}, 16'd0);
    checkOutput("stop_start_count", count(), 16'h0006);

    $display("[TB] clamped preset and borrows");
    setPreset(16'hFC7A);
    applyStimulus(0, 0, 0, 1);
    checkOutput("clamp_load", count(), 16'h9959);
    checkOutput("clamp_idle", {15'd0, running}, 16'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("clamp_tick", count(), 16'h9958);
    applyStimulus(0, 0, 1, 0);
    setPreset(16'h1000);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("borrow_1000", count(), 16'h0959);

    $display("[TB] zero preset and ignored loads");
    applyStimulus(0, 0, 1, 0);
    setPreset(16'h0000);
    applyStimulus(0, 0, 0, 1);
    checkOutput("load_zero", count(), 16'h0000);
    checkOutput("load_zero_fin", {15'd0, fin_pulse}, 16'd0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("start_zero_run", {15'd0, running}, 16'd0);
    checkOutput("start_zero_fin", {15'd0, fin_pulse}, 16'd0);
    setPreset(16'h0031);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_0030", count(), 16'h0030);
    setPreset(16'h0045);
    applyStimulus(0, 0, 0, 1);
    checkOutput("run_load_ignored", count(), 16'h0030);
    checkOutput("run_load_running", {15'd0, running}, 16'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_continue", count(), 16'h0029);

    $display("[TB] simultaneous requests in IDLE");
    applyStimulus(0, 0, 1, 0);
    setPreset(16'h0012);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pause_load_idle", count(), 16'h0012);
    setPreset(16'h0034);
    applyStimulus(1, 1, 0, 1);
    checkOutput("multi_count", count(), 16'h0034);
    checkOutput("multi_running", {15'd0, running}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
